ap_chain_master: RTL and testbench
==================================

AP_CHAIN_MASTER -- requirements
Module: ap_chain_master

Interface
REQ-001 Parameter TIMEOUT, default 64, meaning max cycles from ap_start assertion to ap_done before an error response (1..65535).
REQ-002 clk  in  1  single clock; all flops on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 cmd_valid  in  1  command offered by the host.
REQ-005 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-006 cmd_rd_wr  in  1  1 = read, 0 = write.
REQ-007 cmd_addr  in  32  target register address.
REQ-008 cmd_wdata  in  32  write data.
REQ-009 rsp_valid  out  1  response available.
REQ-010 rsp_ready  in  1  host consumes response.
REQ-011 rsp_data  out  32  read data; 0 for writes and errors.
REQ-012 rsp_err  out  1  1 = timeout.
REQ-013 hold  in  1  stall request; freezes the block and the downstream stage.
REQ-014 addr, wr_data  out  32 each  downstream address and write data.
REQ-015 rd_wr  out  1  downstream direction.
REQ-016 ap_start, ap_continue, ap_ce  out  1 each  downstream ap_ctrl_chain controls.
REQ-017 ap_ready, ap_done, ap_idle  in  1 each  downstream status.
REQ-018 ap_return  in  32  downstream read data, valid while ap_done is high on a read.
REQ-019 txn_count  out  16  completed transactions, including errors.

Function
REQ-020 The FSM SHALL have states IDLE, ISSUE, WAIT, ACK, RESP, and advance only when hold=0.
REQ-021 ap_ce SHALL equal !hold while reset=0, and SHALL be 0 while reset=1.
REQ-022 cmd_ready SHALL be 1 only in IDLE with hold=0.
REQ-023 Command accepted in IDLE SHALL cause the following:
- addr, wr_data and rd_wr are latched from cmd_*.
- The FSM moves to ISSUE.
- ap_start is 1 from the next cycle.
REQ-024 addr, wr_data and rd_wr SHALL remain stable from ISSUE until the FSM returns to IDLE.
REQ-025 ISSUE SHALL behave as follows:
- ap_start is held at 1.
- Sampling ap_ready=1 moves the FSM to WAIT, with ap_start 0 from the next cycle.
- Sampling ap_done=1 moves the FSM to ACK directly.
REQ-026 WAIT SHALL hold ap_start=0 and move to ACK on sampling ap_done=1.
REQ-027 On the ap_done sample edge, rsp_data SHALL load ap_return if rd_wr=1, else 0, and rsp_err SHALL load 0.
REQ-028 ACK SHALL last exactly one cycle, with ap_continue=1 and ap_start=0, then move to RESP.
REQ-029 ap_continue SHALL be 0 in every state except ACK.
REQ-030 RESP SHALL hold rsp_valid=1, rsp_data and rsp_err stable until rsp_ready=1, then move to IDLE.
REQ-031 RESP SHALL return to IDLE even if hold=1 at the handshake edge.
REQ-032 txn_count SHALL increment by one on each RESP handshake and wrap from 0xFFFF to 0.
REQ-033 ap_start, ap_continue and rsp_valid SHALL be registered outputs.
REQ-034 The timeout counter (16 bits) SHALL clear on command accept and increment each non-hold cycle in ISSUE or WAIT.
REQ-035 When the timeout count reaches TIMEOUT, the block SHALL do all of the following:
- Move to RESP with rsp_err=1 and rsp_data=0.
- Drive ap_start=0.
- Skip ACK, so ap_continue is not pulsed.
REQ-036 If ap_done and the timeout occur on the same edge, ap_done SHALL win (normal response).
REQ-037 hold=1 SHALL freeze the state, the timeout counter and all registered outputs.
REQ-038 The block SHALL ignore ap_done and ap_ready in IDLE and RESP.
REQ-039 No new command SHALL be accepted while rsp_valid=1 (single outstanding transaction).

Reset
REQ-040 While reset=1, the block SHALL hold the following values:
- State IDLE.
- ap_start=0, ap_continue=0, ap_ce=0.
- rsp_valid=0, rsp_err=0, rsp_data=0.
- addr=0, wr_data=0, rd_wr=0.
- txn_count=0, timeout counter 0.
- cmd_ready=0.
REQ-041 Reset asserted mid-transaction SHALL abort it with no response, and the first command after deassertion SHALL be accepted normally.

Verification
REQ-042 Write 0x0000_1234 to addr 0 against the downstream stage -> the following, in order:
- ap_start high until ap_ready is sampled.
- One-cycle ap_continue.
- rsp_valid with rsp_data=0 and rsp_err=0.
- txn_count=1.
REQ-043 Read of addr 0 after the REQ-042 write -> rsp_data=0x0000_1234, ap_continue pulses for exactly one cycle, and ap_start is 0 when the downstream stage returns to idle.
REQ-044 Downstream holds ap_done=0 (TIMEOUT=8) -> rsp_err=1 and rsp_data=0 after 8 ISSUE/WAIT cycles, ap_continue never asserted, ap_start=0.
REQ-045 hold=1 for 5 cycles mid-WAIT -> ap_ce=0 for 5 cycles, state and outputs frozen, and the transaction completes normally afterwards.
REQ-046 rsp_ready held 0 for 10 cycles -> rsp_valid stays 1, cmd_ready stays 0, and rsp_data is unchanged.
REQ-047 reset pulse during ISSUE -> all outputs zero immediately (asynchronous), and the next write/read pair returns the correct data.

Source files
------------

// File: rtl/ap_chain_master.sv
// Host-side master for an ap_ctrl_chain downstream stage: turns one register
// command at a time into an ap_start/ap_done/ap_continue exchange with a timeout.
module ap_chain_master #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rd_wr,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    input  logic        hold,
    output logic [31:0] addr,
    output logic [31:0] wr_data,
    output logic        rd_wr,
    output logic        ap_start,
    output logic        ap_continue,
    output logic        ap_ce,
    input  logic        ap_ready,
    input  logic        ap_done,
    input  logic        ap_idle,
    input  logic [31:0] ap_return,
    output logic [15:0] txn_count
);

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK,
        RESP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] tmo_count;
    logic [15:0] tmo_next;
    logic        accept;
    logic        ready_hit;
    logic        done_hit;
    logic        tmo_hit;
    logic        ack_leave;
    logic        rsp_handshake;
    logic        busy_tick;

    // ap_idle carries no information this master needs; the FSM tracks the stage itself.
    logic unused_idle;
    assign unused_idle = ap_idle;

    assign ap_ce     = !hold && !reset;
    assign cmd_ready = (state == IDLE) && !hold && !reset;
    assign busy_tick = ((state == ISSUE) || (state == WAIT)) && !hold;
    assign tmo_next  = tmo_count + 16'd1;

    always_comb begin
        state_next    = state;
        accept        = 1'b0;
        ready_hit     = 1'b0;
        done_hit      = 1'b0;
        tmo_hit       = 1'b0;
        ack_leave     = 1'b0;
        rsp_handshake = 1'b0;
        case (state)
            IDLE: begin
                if (!hold && cmd_valid) begin
                    accept     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                // ap_done beats both the timeout and ap_ready on the same edge.
                if (!hold) begin
                    if (ap_done) begin
                        done_hit   = 1'b1;
                        state_next = ACK;
                    end else if (tmo_next == TIMEOUT_LIMIT) begin
                        tmo_hit    = 1'b1;
                        state_next = RESP;
                    end else if (ap_ready) begin
                        ready_hit  = 1'b1;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!hold) begin
                    if (ap_done) begin
                        done_hit   = 1'b1;
                        state_next = ACK;
                    end else if (tmo_next == TIMEOUT_LIMIT) begin
                        tmo_hit    = 1'b1;
                        state_next = RESP;
                    end
                end
            end
            ACK: begin
                if (!hold) begin
                    ack_leave  = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                // The host handshake completes regardless of hold.
                if (rsp_ready) begin
                    rsp_handshake = 1'b1;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr        <= 32'd0;
            wr_data     <= 32'd0;
            rd_wr       <= 1'b0;
            ap_start    <= 1'b0;
            ap_continue <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= 32'd0;
            rsp_err     <= 1'b0;
            txn_count   <= 16'd0;
            tmo_count   <= 16'd0;
        end else begin
            if (accept) begin
                addr      <= cmd_addr;
                wr_data   <= cmd_wdata;
                rd_wr     <= cmd_rd_wr;
                ap_start  <= 1'b1;
                tmo_count <= 16'd0;
            end
            if (busy_tick) begin
                tmo_count <= tmo_next;
            end
            if (ready_hit) begin
                ap_start <= 1'b0;
            end
            if (done_hit) begin
                ap_start    <= 1'b0;
                ap_continue <= 1'b1;
                rsp_data    <= rd_wr ? ap_return : 32'd0;
                rsp_err     <= 1'b0;
            end
            // A timed-out transaction skips ACK, so the stage never sees ap_continue.
            if (tmo_hit) begin
                ap_start  <= 1'b0;
                rsp_valid <= 1'b1;
                rsp_data  <= 32'd0;
                rsp_err   <= 1'b1;
            end
            if (ack_leave) begin
                ap_continue <= 1'b0;
                rsp_valid   <= 1'b1;
            end
            if (rsp_handshake) begin
                rsp_valid <= 1'b0;
                txn_count <= txn_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ap_chain_master.sv
// Randomised scoreboard bench for ap_chain_master with a behavioural
// downstream register-file stage and a separate response monitor.
module tb_ap_chain_master;

    localparam int TMO          = 8;
    localparam int KIND_NORMAL  = 0;
    localparam int KIND_STALL   = 1;
    localparam int KIND_ABORT   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rd_wr;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        hold;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        rd_wr;
    logic        ap_start;
    logic        ap_continue;
    logic        ap_ce;
    logic        ap_ready;
    logic        ap_done;
    logic        ap_idle;
    logic [31:0] ap_return;
    logic [15:0] txn_count;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t        sb_q[$];
    logic [31:0] model_mem [logic [31:0]];
    logic [15:0] txn_model = 16'd0;
    int          checks    = 0;
    int          failures  = 0;

    // Downstream stage environment
    logic [31:0] ds_mem [logic [31:0]];
    logic        ds_busy;
    logic        ds_done_wait;
    int          ds_cnt;
    logic [31:0] ds_a;
    logic [31:0] ds_w;
    logic        ds_rw;
    int          ds_d;
    logic        ds_fin;
    logic [31:0] ds_fa;
    logic [31:0] ds_fw;
    logic        ds_frw;
    int          ds_delay_sel = -1;
    bit          ds_stall     = 1'b0;
    bit          ds_abort     = 1'b0;
    bit          hold_rand    = 1'b0;
    bit          rdy_rand     = 1'b0;

    always #5 clk = ~clk;

    ap_chain_master #(.TIMEOUT(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_rd_wr   (cmd_rd_wr),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .hold        (hold),
        .addr        (addr),
        .wr_data     (wr_data),
        .rd_wr       (rd_wr),
        .ap_start    (ap_start),
        .ap_continue (ap_continue),
        .ap_ce       (ap_ce),
        .ap_ready    (ap_ready),
        .ap_done     (ap_done),
        .ap_idle     (ap_idle),
        .ap_return   (ap_return),
        .txn_count   (txn_count)
    );

    assign ap_idle = !ds_busy;

    // The stage accepts ap_start, pulses ap_ready, finishes after a short delay
    // and keeps ap_done up until it sees ap_continue; ap_ce freezes it.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ds_busy      <= 1'b0;
            ds_done_wait <= 1'b0;
            ds_cnt       <= 0;
            ap_ready     <= 1'b0;
            ap_done      <= 1'b0;
            ap_return    <= 32'd0;
        end else if (ds_abort) begin
            ds_busy      <= 1'b0;
            ds_done_wait <= 1'b0;
            ds_cnt       <= 0;
            ap_ready     <= 1'b0;
            ap_done      <= 1'b0;
        end else if (ap_ce) begin
            ds_fin   = 1'b0;
            ds_fa    = 32'd0;
            ds_fw    = 32'd0;
            ds_frw   = 1'b0;
            ap_ready <= 1'b0;
            if (ds_done_wait) begin
                if (ap_continue) begin
                    ap_done      <= 1'b0;
                    ds_done_wait <= 1'b0;
                    ds_busy      <= 1'b0;
                end
            end else if (!ds_busy) begin
                if (ap_start) begin
                    ds_busy  <= 1'b1;
                    ap_ready <= 1'b1;
                    ds_a     <= addr;
                    ds_w     <= wr_data;
                    ds_rw    <= rd_wr;
                    ds_d = (ds_delay_sel < 0) ? int'($urandom_range(0, 3)) : ds_delay_sel;
                    if (ds_stall) begin
                        ds_cnt <= 0;
                    end else if (ds_d == 0) begin
                        ds_fin = 1'b1;
                        ds_fa  = addr;
                        ds_fw  = wr_data;
                        ds_frw = rd_wr;
                    end else begin
                        ds_cnt <= ds_d;
                    end
                end
            end else if (ds_cnt > 0) begin
                if (ds_cnt == 1) begin
                    ds_fin = 1'b1;
                    ds_fa  = ds_a;
                    ds_fw  = ds_w;
                    ds_frw = ds_rw;
                end
                ds_cnt <= ds_cnt - 1;
            end
            if (ds_fin) begin
                ap_done      <= 1'b1;
                ds_done_wait <= 1'b1;
                if (ds_frw) begin
                    ap_return <= ds_mem.exists(ds_fa) ? ds_mem[ds_fa] : 32'd0;
                end else begin
                    ds_mem[ds_fa] = ds_fw;
                    ap_return <= $urandom;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : 32'd0;
    endfunction

    // Offer one command; the expected response is queued the moment it is accepted.
    task automatic applyStimulus(input logic rw, input logic [31:0] a, input logic [31:0] w, input int kind);
        rsp_t exp_rsp;
        bit   taken = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_rd_wr = rw;
        cmd_addr  = a;
        cmd_wdata = w;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                taken = 1'b1;
                break;
            end
        end
        if (!taken) begin
            checks++;
            failures++;
            $display("[TB] FAIL cmd_accept: got no cmd_ready, expected acceptance within 300 cycles");
            cmd_valid = 1'b0;
            return;
        end
        exp_rsp.data = 32'd0;
        exp_rsp.err  = (kind == KIND_STALL);
        if (kind == KIND_NORMAL) begin
            if (rw) exp_rsp.data = modelRead(a);
            else    model_mem[a] = w;
        end
        if (kind != KIND_ABORT) sb_q.push_back(exp_rsp);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic waitDrain();
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain: got %0d responses outstanding, expected 0", sb_q.size());
        end
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_ap_start", 32'(ap_start), 32'd0);
        checkOutput("rst_ap_continue", 32'(ap_continue), 32'd0);
        checkOutput("rst_ap_ce", 32'(ap_ce), 32'd0);
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("rst_rsp_data", rsp_data, 32'd0);
        checkOutput("rst_addr", addr, 32'd0);
        checkOutput("rst_wr_data", wr_data, 32'd0);
        checkOutput("rst_rd_wr", 32'(rd_wr), 32'd0);
        checkOutput("rst_txn_count", 32'(txn_count), 32'd0);
    endtask

    // Response monitor: scoreboard pops, stability under backpressure, pulse counts.
    initial begin
        rsp_t        got;
        int          cont_cnt    = 0;
        bit          prev_valid  = 1'b0;
        logic [31:0] prev_data   = 32'd0;
        logic        prev_err    = 1'b0;
        bit          txn_pending = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cont_cnt    = 0;
                prev_valid  = 1'b0;
                txn_pending = 1'b0;
                continue;
            end
            checkOutput("ap_ce", 32'(ap_ce), 32'(!hold));
            if (txn_pending) begin
                checkOutput("txn_count", 32'(txn_count), 32'(txn_model));
                txn_pending = 1'b0;
            end
            if (ap_continue && !hold) cont_cnt++;
            if (rsp_valid) checkOutput("cmd_ready_busy", 32'(cmd_ready), 32'd0);
            if (prev_valid) begin
                checkOutput("rsp_valid_held", 32'(rsp_valid), 32'd1);
                checkOutput("rsp_data_stable", rsp_data, prev_data);
                checkOutput("rsp_err_stable", 32'(rsp_err), 32'(prev_err));
            end
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_rsp: got data 0x%0h, expected no response", rsp_data);
                end else begin
                    got = sb_q.pop_front();
                    checkOutput("rsp_data", rsp_data, got.data);
                    checkOutput("rsp_err", 32'(rsp_err), 32'(got.err));
                    checkOutput("ap_continue_pulses", 32'(cont_cnt), got.err ? 32'd0 : 32'd1);
                    checkOutput("ap_start_at_rsp", 32'(ap_start), 32'd0);
                end
                cont_cnt    = 0;
                txn_model   = txn_model + 16'd1;
                txn_pending = 1'b1;
                prev_valid  = 1'b0;
            end else begin
                prev_valid = rsp_valid;
                prev_data  = rsp_data;
                prev_err   = rsp_err;
            end
        end
    end

    // Random hold / rsp_ready drivers, active only when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (hold_rand) hold = ($urandom_range(0, 5) == 0);
            if (rdy_rand)  rsp_ready = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        int          n;
        bit          found;
        logic [19:0] snap;
        logic        rw_r;
        logic [31:0] a_r;
        logic [31:0] w_r;

        reset     = 1'b1;
        hold      = 1'b0;
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        cmd_rd_wr = 1'b0;
        cmd_addr  = 32'd0;
        cmd_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs();
        reset = 1'b0;

        $display("[TB] write then read back through the stage");
        rsp_ready = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0000_1234, KIND_NORMAL);
        applyStimulus(1'b1, 32'h0, 32'h0, KIND_NORMAL);
        waitDrain();

        $display("[TB] downstream never finishes: timeout response");
        ds_stall  = 1'b1;
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 32'h10, 32'h5555_5555, KIND_STALL);
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (rsp_valid) break;
            n++;
        end
        checkOutput("timeout_latency", 32'(n), 32'(TMO));
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        waitDrain();
        @(posedge clk);
        #1;
        ds_stall = 1'b0;
        ds_abort = 1'b1;
        @(posedge clk);
        #1;
        ds_abort = 1'b0;
        applyStimulus(1'b1, 32'h10, 32'h0, KIND_NORMAL);
        waitDrain();

        $display("[TB] hold for five cycles in the middle of WAIT");
        ds_delay_sel = 3;
        applyStimulus(1'b1, 32'h0, 32'h0, KIND_NORMAL);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!ap_start && !ap_idle && !ap_done && !rsp_valid) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("reach_wait", 32'(found), 32'd1);
        @(posedge clk);
        #1;
        hold = 1'b1;
        snap = {ap_start, ap_continue, rsp_valid, rsp_err, txn_count};
        repeat (5) begin
            @(negedge clk);
            checkOutput("hold_ap_ce", 32'(ap_ce), 32'd0);
            checkOutput("hold_frozen", 32'({ap_start, ap_continue, rsp_valid, rsp_err, txn_count}), 32'(snap));
        end
        @(posedge clk);
        #1;
        hold = 1'b0;
        waitDrain();
        ds_delay_sel = -1;

        $display("[TB] response backpressure for ten cycles");
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 32'h20, 32'hA5A5_0F0F, KIND_NORMAL);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("bp_rsp_valid", 32'(found), 32'd1);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        waitDrain();

        $display("[TB] reset pulse while a write is in ISSUE");
        ds_delay_sel = 3;
        applyStimulus(1'b0, 32'h8, 32'hDEAD_BEEF, KIND_ABORT);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkResetOutputs();
        sb_q.delete();
        txn_model = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        ds_delay_sel = -1;
        applyStimulus(1'b0, 32'h4, 32'hCAFE_F00D, KIND_NORMAL);
        applyStimulus(1'b1, 32'h4, 32'h0, KIND_NORMAL);
        applyStimulus(1'b1, 32'h8, 32'h0, KIND_NORMAL);
        waitDrain();

        $display("[TB] randomised traffic with random hold and backpressure");
        hold_rand = 1'b1;
        rdy_rand  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rw_r = 1'($urandom_range(0, 1));
            a_r  = 32'($urandom_range(0, 7)) << 2;
            w_r  = $urandom;
            applyStimulus(rw_r, a_r, w_r, KIND_NORMAL);
        end
        @(posedge clk);
        #1;
        hold_rand = 1'b0;
        rdy_rand  = 1'b0;
        hold      = 1'b0;
        rsp_ready = 1'b1;
        waitDrain();
        repeat (2) @(negedge clk);
        checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
